// File: rtl/evt_pkg.sv
// Shared constants and helpers for the receiver at the tail of the
// bundled-data 2-phase micropipeline.
package evt_pkg;

  localparam int EVT_SYNC_STAGES_DEF = 2;

  // Level of the 2-phase req/ack wires after reset; the first event is a 0->1 transition.
  localparam logic EVT_PHASE_INIT = 1'b0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/evt_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level into the clk domain.
// Resets to the idle phase level so a reset pipeline reads as "no event".
module evt_sync_bit
  import evt_pkg::*;
#(
  parameter int SYNC_STAGES = EVT_SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the async level through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= {SYNC_STAGES{EVT_PHASE_INIT}};
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/evt_sync_rx.sv
// Clocked receiver for a 2-phase bundled-data micropipeline: synchronises the
// request, captures the word into a small FIFO and returns the acknowledge.
module evt_sync_rx
  import evt_pkg::*;
#(
  parameter int width       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = EVT_SYNC_STAGES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      evt_req,
  input  logic [width-1:0]          evt_data,
  output logic                      evt_ack,
  output logic [width-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [clog2(DEPTH+1)-1:0] fill_count
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1'b1);

  logic             w_req_s;
  logic             w_pending;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_nxt;

  logic             r_ack;
  logic             r_valid;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [width-1:0] r_mem [DEPTH];

  evt_sync_bit #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (evt_req),
    .o_sync  (w_req_s)
  );

  // A pending event is accepted only while there is room; a pop in the same
  // cycle never frees space early, so a full FIFO simply withholds the ack.
  assign w_pending = w_req_s ^ r_ack;
  assign w_push    = w_pending & (r_count < FULL_COUNT);
  assign w_pop     = r_valid & out_ready;

  // Next occupancy from the push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + COUNT_ONE;
      2'b01:   w_count_nxt = r_count - COUNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Handshake, pointer and occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack    <= EVT_PHASE_INIT;
      r_valid  <= 1'b0;
      r_count  <= {CW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else begin
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != {CW{1'b0}});
      if (w_push) begin
        r_ack    <= ~r_ack;
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_ack    <= r_ack;
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // Word storage; evt_data is stable here because req_s lags evt_req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {width{1'b0}};
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= evt_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  assign evt_ack    = r_ack;
  assign out_valid  = r_valid;
  assign fill_count = r_count;
  assign out_data   = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_evt_sync_rx.sv
// Self-checking bench for evt_sync_rx: a queue-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_evt_sync_rx;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       evt_req = 1'b0;
  logic [7:0] evt_data = 8'h00;
  logic       evt_ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] fill_count;

  logic       req3 = 1'b0;
  logic [7:0] data3 = 8'h00;
  logic       ack3;
  logic [7:0] odata3;
  logic       valid3;
  logic       ready3 = 1'b0;
  logic [2:0] count3;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got[$];
  int         max_fill = 0;
  bit         track_max = 1'b0;

  logic       m_sync [S];
  logic       m_ack = 1'b0;
  logic [7:0] m_q[$];

  always #5 clk = ~clk;

  evt_sync_rx #(.width(8), .DEPTH(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .evt_req(evt_req), .evt_data(evt_data),
    .evt_ack(evt_ack), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fill_count(fill_count)
  );

  evt_sync_rx #(.width(8), .DEPTH(D), .SYNC_STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .evt_req(req3), .evt_data(data3),
    .evt_ack(ack3), .out_data(odata3), .out_valid(valid3),
    .out_ready(ready3), .fill_count(count3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: req_s is evt_req seen S edges late; the FIFO is a queue.
  initial begin
    for (int i = 0; i < S; i++) m_sync[i] = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_ack = 1'b0;
        for (int i = 0; i < S; i++) m_sync[i] = 1'b0;
      end else begin : step
        bit rs, push, pop;
        rs   = m_sync[S-1];
        push = (rs != m_ack) && (m_q.size() < D);
        pop  = (m_q.size() > 0) && out_ready;
        if (pop) void'(m_q.pop_front());
        if (push) begin
          m_q.push_back(evt_data);
          m_ack = ~m_ack;
        end
        for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = evt_req;
      end
    end
  end

  // Compare DUT against the model every cycle outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("cyc_ack", evt_ack, m_ack);
        check("cyc_valid", out_valid, m_q.size() > 0);
        check("cyc_count", fill_count, m_q.size());
        if (m_q.size() > 0) check("cyc_data", out_data, m_q[0]);
        if (track_max && fill_count > max_fill) max_fill = fill_count;
      end
    end
  end

  // Record every word the consumer accepts.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst && out_valid && out_ready) got.push_back(out_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_acked(input string name);
    int k;
    k = 0;
    while (evt_ack !== evt_req && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (evt_ack !== evt_req) check(name, evt_ack, evt_req);
  endtask

  task automatic send_event(input logic [7:0] d);
    wait_acked("ack_timeout");
    evt_data = d;
    evt_req  = ~evt_req;
  endtask

  task automatic wait_got(input int n, input string name);
    int k;
    k = 0;
    while (got.size() < n && k < 80) begin
      @(negedge clk);
      k++;
    end
    check(name, got.size(), n);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2;
    check("rst_ack", evt_ack, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", fill_count, 3'd0);
    check("rst_data", out_data, 8'h00);
    rst = 1'b0;

    // One event: ack and valid appear at the third edge.
    @(negedge clk);
    evt_data = 8'hA5;
    evt_req  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("lat_ack", evt_ack, k == 3);
      check("lat_valid", out_valid, k == 3);
    end
    check("one_data", out_data, 8'hA5);
    check("one_count", fill_count, 3'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("one_pop_valid", out_valid, 1'b0);
    check("one_pop_count", fill_count, 3'd0);

    // Full back-pressure: the fifth event waits for space.
    got.delete();
    for (int i = 1; i <= 5; i++) send_event(8'(i));
    repeat (8) @(negedge clk);
    check("bp_count", fill_count, 3'd4);
    check("bp_ack_held", evt_ack, 1'b1);
    check("bp_req_level", evt_req, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_pop_count", fill_count, 3'd3);
    check("bp_pop_ack", evt_ack, 1'b1);
    @(negedge clk);
    check("bp_push_count", fill_count, 3'd4);
    check("bp_push_ack", evt_ack, 1'b0);
    out_ready = 1'b1;
    wait_got(5, "bp_drain_size");
    out_ready = 1'b0;
    for (int i = 0; i < 5 && i < got.size(); i++) check("bp_order", got[i], i + 1);

    // Streaming with a free-running consumer.
    @(negedge clk);
    got.delete();
    out_ready = 1'b1;
    max_fill  = 0;
    track_max = 1'b1;
    for (int i = 0; i < 16; i++) send_event(8'h30 + 8'(i));
    wait_got(16, "stream_size");
    track_max = 1'b0;
    check("stream_max_fill", max_fill, 1);
    for (int i = 0; i < 16 && i < got.size(); i++) check("stream_order", got[i], 8'h30 + i);
    out_ready = 1'b0;

    // Push and pop on the same edge at fill_count 2.
    @(negedge clk);
    got.delete();
    send_event(8'h41);
    send_event(8'h42);
    wait_acked("sim_ack_timeout");
    @(negedge clk);
    check("sim_pre_count", fill_count, 3'd2);
    send_event(8'h43);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("sim_count", fill_count, 3'd2);
    check("sim_ack", evt_ack, evt_req);
    out_ready = 1'b1;
    wait_got(3, "sim_drain_size");
    out_ready = 1'b0;
    for (int i = 0; i < 3 && i < got.size(); i++) check("sim_order", got[i], 8'h41 + i);

    // Async reset between the request toggle and its push edge.
    @(negedge clk);
    got.delete();
    for (int i = 0; i < 3; i++) send_event(8'h51 + 8'(i));
    wait_acked("rst_fill_timeout");
    @(negedge clk);
    check("rst_pre_count", fill_count, 3'd3);
    send_event(8'h54);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ack", evt_ack, 1'b0);
    check("arst_valid", out_valid, 1'b0);
    check("arst_count", fill_count, 3'd0);
    check("arst_data", out_data, 8'h00);
    evt_req = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_count", fill_count, 3'd0);
    check("post_rst_ack", evt_ack, 1'b0);
    check("post_rst_valid", out_valid, 1'b0);

    // Three-stage synchroniser: one more edge of latency.
    @(negedge clk);
    data3 = 8'hA5;
    req3  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check("s3_ack", ack3, k == 4);
      check("s3_valid", valid3, k == 4);
    end
    check("s3_data", odata3, 8'hA5);
    check("s3_count", count3, 3'd1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
